// File: rtl/bloco_operativo.sv
// Datapath beside the controller: RX/RH/RS registers, one ALU with post-op shifter,
// inicio/pronto job tracking, result latch and job counter. Optional: OVERFLOW_FLAG_EN.
module bloco_operativo_alu #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    h,
  input  logic [1:0]              m2,
`ifdef OVERFLOW_FLAG_EN
  output logic                    ovf,
`endif
  output logic signed [WIDTH-1:0] y
);
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] raw;

`ifdef OVERFLOW_FLAG_EN
  localparam int PW = 2*WIDTH;
  logic signed [PW-1:0] ax, bx, full;
  logic                 raw_ovf;

  // Full-precision result, exact for both sum and product at 2*WIDTH bits.
  always_comb begin
    ax      = {{WIDTH{a[WIDTH-1]}}, a};
    bx      = {{WIDTH{b[WIDTH-1]}}, b};
    full    = h ? ax * bx : ax + bx;
    raw     = full[WIDTH-1:0];
    raw_ovf = (full != {{WIDTH{raw[WIDTH-1]}}, raw});
  end

  always_comb begin
    ovf = raw_ovf;
    case (m2)
      2'd1:    ovf = raw_ovf | (raw == MIN_V);
      2'd3:    ovf = raw_ovf | (raw[WIDTH-1] != raw[WIDTH-2]);
      default: ovf = raw_ovf;
    endcase
  end
`else
  always_comb raw = h ? a * b : a + b;
`endif

  // Negating MIN_V wraps back to MIN_V in WIDTH-bit arithmetic.
  always_comb begin
    y = raw;
    case (m2)
      2'd1:    y = -raw;
      2'd2:    y = raw >>> 1;
      2'd3:    y = raw <<< 1;
      default: y = raw;
    endcase
  end
endmodule

module bloco_operativo #(
  parameter int WIDTH = 8,
  parameter int K0    = 1,
  parameter int K1    = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             pronto,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  input  logic             H,
  input  logic             LX,
  input  logic             LH,
  input  logic             LS,
  input  logic [WIDTH-1:0] x_in,
  output logic [WIDTH-1:0] resultado,
  output logic             resultado_valido,
  output logic             ocupado,
`ifdef OVERFLOW_FLAG_EN
  output logic             overflow,
`endif
  output logic [CNT_W-1:0] contagem
);
  localparam logic signed [WIDTH-1:0] K0_V = WIDTH'(K0);
  localparam logic signed [WIDTH-1:0] K1_V = WIDTH'(K1);

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       lx;
    logic       lh;
    logic       ls;
  } ctrl_t;

  ctrl_t                   ctl;
  logic signed [WIDTH-1:0] rx, rh, rs;
  logic signed [WIDTH-1:0] op_a, op_b, alu_out;
  logic                    prev_pronto;
  logic                    pronto_rise, job_start;

  assign ctl = '{m0: M0, m1: M1, m2: M2, h: H, lx: LX, lh: LH, ls: LS};

  always_comb begin
    op_a = rx;
    case (ctl.m0)
      2'd1:    op_a = rh;
      2'd2:    op_a = rs;
      2'd3:    op_a = K0_V;
      default: op_a = rx;
    endcase
  end

  always_comb begin
    op_b = rx;
    case (ctl.m1)
      2'd1:    op_b = rh;
      2'd2:    op_b = rs;
      2'd3:    op_b = K1_V;
      default: op_b = rx;
    endcase
  end

`ifdef OVERFLOW_FLAG_EN
  logic alu_ovf;
`endif

  bloco_operativo_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (op_a),
    .b   (op_b),
    .h   (ctl.h),
    .m2  (ctl.m2),
`ifdef OVERFLOW_FLAG_EN
    .ovf (alu_ovf),
`endif
    .y   (alu_out)
  );

  // A pronto rise always wins; a new job only starts with pronto low.
  assign pronto_rise = pronto & ~prev_pronto;
  assign job_start   = inicio & ~ocupado & ~pronto;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx               <= '0;
      rh               <= '0;
      rs               <= '0;
      resultado        <= '0;
      resultado_valido <= 1'b0;
      ocupado          <= 1'b0;
      contagem         <= '0;
      prev_pronto      <= 1'b0;
    end else begin
      if (ctl.lx) rx <= x_in;
      if (ctl.lh) rh <= alu_out;
      if (ctl.ls) rs <= alu_out;
      prev_pronto <= pronto;
      if (pronto_rise) begin
        resultado        <= rs;
        resultado_valido <= 1'b1;
        ocupado          <= 1'b0;
        contagem         <= contagem + 1'b1;
      end else if (job_start) begin
        ocupado          <= 1'b1;
        resultado_valido <= 1'b0;
      end
    end
  end

`ifdef OVERFLOW_FLAG_EN
  // Sticky; a load that overflows on the job-start edge still sets it.
  always_ff @(posedge clk) begin
    if (rst)                             overflow <= 1'b0;
    else if ((ctl.lh | ctl.ls) & alu_ovf) overflow <= 1'b1;
    else if (job_start)                  overflow <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_bloco_operativo.sv
// Directed bench for bloco_operativo: stimulus pushes expected job results, a negedge
// monitor pops and checks whenever contagem advances.
module tb_bloco_operativo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inicio, pronto, H, LX, LH, LS;
  logic [1:0] M0, M1, M2;
  logic [7:0] x_in, resultado, contagem;
  logic       resultado_valido, ocupado;
`ifdef OVERFLOW_FLAG_EN
  logic       overflow;
`endif

  always #5 clk = ~clk;

  bloco_operativo #(.WIDTH(8), .K0(1), .K1(3), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .inicio           (inicio),
    .pronto           (pronto),
    .M0               (M0),
    .M1               (M1),
    .M2               (M2),
    .H                (H),
    .LX               (LX),
    .LH               (LH),
    .LS               (LS),
    .x_in             (x_in),
    .resultado        (resultado),
    .resultado_valido (resultado_valido),
    .ocupado          (ocupado),
`ifdef OVERFLOW_FLAG_EN
    .overflow         (overflow),
`endif
    .contagem         (contagem)
  );

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_cnt;
  logic [7:0] last_cnt = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every contagem step must match the next pending job.
  always @(negedge clk) begin
    if (rst) last_cnt = contagem;
    else if (contagem !== last_cnt) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_job: contagem=%0d with no pending job", contagem);
      end else begin
        e = sb.pop_front();
        chk("job_resultado", {24'd0, resultado}, {24'd0, e.res});
        chk("job_valido", {31'd0, resultado_valido}, 32'd1);
        chk("job_contagem", {24'd0, contagem}, {24'd0, e.cnt});
      end
      last_cnt = contagem;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    M0 = 0; M1 = 0; M2 = 0; H = 0; LX = 0; LH = 0; LS = 0;
    inicio = 0; pronto = 0; x_in = 0;
  endtask

  task automatic op(input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                    input logic h, input logic lx, input logic lh, input logic ls,
                    input logic [7:0] x);
    M0 = m0; M1 = m1; M2 = m2; H = h; LX = lx; LH = lh; LS = ls; x_in = x;
    tick();
    M0 = 0; M1 = 0; M2 = 0; H = 0; LX = 0; LH = 0; LS = 0; x_in = 0;
  endtask

  task automatic ldx(input logic [7:0] x);
    op(0, 0, 0, 0, 1, 0, 0, x);
  endtask

  // RS = 2*x, then RX = 0 so M1=0 adds nothing.
  task automatic set_rs_double(input logic [7:0] x);
    ldx(x);
    op(0, 0, 0, 0, 0, 0, 1, 8'd0);
    ldx(8'd0);
  endtask

  task automatic start();
    inicio = 1;
    tick();
    inicio = 0;
  endtask

  task automatic expect_job(input logic [7:0] res);
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back(exp_t'{res, exp_cnt});
  endtask

  task automatic done(input logic [7:0] res);
    expect_job(res);
    pronto = 1;
    tick();
    pronto = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    exp_cnt = 8'd0;
    rst = 1;
    tick(); tick();
    chk("rst_resultado", {24'd0, resultado}, 32'd0);
    chk("rst_valido", {31'd0, resultado_valido}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_contagem", {24'd0, contagem}, 32'd0);
    rst = 0;

    // Square of 5, then RH = RS + K1, then RH * K1
    start();
    chk("start_ocupado", {31'd0, ocupado}, 32'd1);
    chk("start_valido", {31'd0, resultado_valido}, 32'd0);
    ldx(8'd5);
    op(0, 0, 0, 1, 0, 0, 1, 8'd0);
    op(2, 3, 0, 0, 0, 1, 0, 8'd0);
    done(8'd25);
    chk("done_ocupado", {31'd0, ocupado}, 32'd0);
    op(1, 3, 0, 1, 0, 0, 1, 8'd0);
    done(8'd84);

    // Post-op shifter
    set_rs_double(8'hFD);
    op(2, 0, 2, 0, 0, 0, 1, 8'd0);
    done(8'hFD);
    set_rs_double(8'hFD);
    op(2, 0, 1, 0, 0, 0, 1, 8'd0);
    done(8'd6);
    set_rs_double(8'hFD);
    op(2, 0, 3, 0, 0, 0, 1, 8'd0);
    done(8'hF4);
    set_rs_double(8'hC0);
    op(2, 0, 1, 0, 0, 0, 1, 8'd0);
    done(8'h80);
    ldx(8'hFF);
    op(0, 3, 0, 1, 0, 0, 1, 8'd0);
    ldx(8'd0);
    op(2, 0, 2, 0, 0, 0, 1, 8'd0);
    done(8'hFE);

    // Truncated product 100*100
    ldx(8'd100);
    op(0, 0, 0, 1, 0, 0, 1, 8'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("overflow_set", {31'd0, overflow}, 32'd1);
`endif
    done(8'h10);
    start();
`ifdef OVERFLOW_FLAG_EN
    chk("overflow_clear", {31'd0, overflow}, 32'd0);
`endif

    // inicio while busy is ignored
    inicio = 1;
    tick(); tick();
    inicio = 0;
    chk("busy_ocupado", {31'd0, ocupado}, 32'd1);
    chk("busy_valido", {31'd0, resultado_valido}, 32'd0);
    chk("busy_contagem", {24'd0, contagem}, {24'd0, exp_cnt});

    // inicio with pronto rise, pronto then held 3 cycles
    expect_job(8'h10);
    inicio = 1; pronto = 1;
    tick();
    chk("race_ocupado", {31'd0, ocupado}, 32'd0);
    chk("race_valido", {31'd0, resultado_valido}, 32'd1);
    tick();
    chk("race_no_restart", {31'd0, ocupado}, 32'd0);
    inicio = 0;
    tick();
    pronto = 0;
    tick();
    chk("held_contagem", {24'd0, contagem}, {24'd0, exp_cnt});

    // Simultaneous loads
    ldx(8'd2);
    op(0, 3, 0, 0, 1, 1, 1, 8'd7);
    done(8'd5);
    op(1, 0, 0, 0, 0, 0, 1, 8'd0);
    done(8'd12);

    // Reset mid-job with a pronto rise pending
    start();
    ldx(8'd9);
    op(0, 0, 0, 0, 0, 0, 1, 8'd0);
    pronto = 1; rst = 1;
    tick(); tick();
    chk("midrst_resultado", {24'd0, resultado}, 32'd0);
    chk("midrst_valido", {31'd0, resultado_valido}, 32'd0);
    chk("midrst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("midrst_contagem", {24'd0, contagem}, 32'd0);
    pronto = 0; rst = 0;
    exp_cnt = 8'd0;

    // 256 jobs wrap the counter; RS stays at its reset value 0
    for (int j = 0; j < 256; j++) begin
      start();
      done(8'd0);
    end
    chk("wrap_contagem", {24'd0, contagem}, 32'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d jobs never reported, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
